// File: rtl/mhp_tx_arbiter.sv
// mhp_tx_arbiter: round-robin scheduler sharing the MHP transmit port between
// two packet sources. Serialises one packet at a time (header, then payload),
// stamps the payload length into header bits [15:5] and pops source bytes on
// each MHP data acknowledge. Holds the MHP controller-busy input high while a
// transmit is scheduled.
// Optional ack watchdog: define MHP_ARB_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive cycles without header_sent/ack progress.
module mhp_tx_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_req,
  input  logic [63:0]           i_hdr0,
  input  logic [63:0]           i_hdr1,
  input  logic [10:0]           i_len0,
  input  logic [10:0]           i_len1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic [1:0]            o_pop,
  output logic [1:0]            o_grant,
  output logic [1:0]            o_done,
  output logic                  o_timeout,
  output logic [63:0]           o_mhp_tx_header,
  output logic                  o_mhp_tx_valid,
  output logic [DATA_WIDTH-1:0] o_mhp_tx_data,
  input  logic                  i_mhp_tx_data_ack,
  input  logic                  i_mhp_tx_busy,
  input  logic                  i_mhp_header_sent,
  output logic                  o_controller_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q,  done_d;
  logic        last_q,  last_d;
  logic [10:0] cnt_q,   cnt_d;
  logic [63:0] hdr_q,   hdr_d;
  logic        valid_q, valid_d;

  logic        sel;
  logic [10:0] sel_len;
  logic [63:0] sel_hdr;

`ifdef MHP_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin pick: a lone requester wins, otherwise the one not served last.
  always_comb begin
    sel     = (i_req == 2'b11) ? ~last_q : i_req[1];
    sel_len = sel ? i_len1 : i_len0;
    sel_hdr = sel ? i_hdr1 : i_hdr0;
    sel_hdr[15:5] = sel_len;
  end

  // Next-state and registered-output logic for the packet FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    valid_d = valid_q;
`ifdef MHP_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // done_q gate keeps a zero-length completion (which lands in IDLE)
        // from regranting while the requester is still dropping its request.
        if ((i_req != 2'b00) && !i_mhp_tx_busy && (done_q == 2'b00)) begin
          grant_d = sel ? 2'b10 : 2'b01;
          last_d  = sel;
          hdr_d   = sel_hdr;
          cnt_d   = sel_len;
          valid_d = (sel_len != 11'd0);
          state_d = HDR;
        end
      end
      HDR: begin
        if (cnt_q == 11'd0) begin
          // Zero-length packet: no MHP transaction, complete immediately.
          done_d  = grant_q;
          grant_d = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (i_mhp_header_sent) begin
          state_d = PAYLOAD;
        end
`ifdef MHP_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          done_d    = grant_q;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end
`endif
      end
      PAYLOAD: begin
        if (i_mhp_tx_data_ack) begin
          cnt_d = cnt_q - 11'd1;
          if (cnt_q == 11'd1) begin
            done_d  = grant_q;
            grant_d = '0;
            valid_d = 1'b0;
            state_d = DRAIN;
          end
        end
`ifdef MHP_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          done_d    = grant_q;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (!i_mhp_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      hdr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      valid_q <= valid_d;
    end
  end

`ifdef MHP_ARB_TIMEOUT_EN
  // Watchdog count: consecutive stalled cycles in HDR/PAYLOAD.
  always_comb begin
    wd_d = '0;
    if (((state_q == HDR) || (state_q == PAYLOAD)) && (state_d == state_q) &&
        !i_mhp_tx_data_ack && !i_mhp_header_sent) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_grant           = grant_q;
  assign o_done            = done_q;
  assign o_mhp_tx_valid    = valid_q;
  assign o_mhp_tx_header   = hdr_q;
  assign o_controller_busy = (state_q != IDLE);
  assign o_pop             = ((state_q == PAYLOAD) && i_mhp_tx_data_ack) ? grant_q : 2'b00;
  assign o_mhp_tx_data     = grant_q[0] ? i_data0 :
                             grant_q[1] ? i_data1 : '0;

endmodule
